led_sequencer: RTL and testbench
================================

# led_sequencer

Fabric-side controller owning the 8-bit LED array and reading the 4-bit switch array on the DE10-Nano. It shares the LEDs between HPS software (Avalon-MM slave on the lightweight bridge) and a local pattern engine selected by debounced switches. Sits between the Qsys interconnect and the `led_array_io_export` / `switch_array_io_export` conduits.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles before a switch change is accepted (20 ms at 50 MHz).
- `STEP_DIV_RST`, 12500000: reset value of STEP_DIV, in clock cycles per pattern step (250 ms at 50 MHz).
- `clk_clk`  in  1  system clock, 50 MHz.
- `reset_reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `avs_address`  in  2  word address.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data, valid 1 cycle after `avs_read`.
- `switch_array_io_export`  in  4  raw asynchronous switches.
- `led_array_io_export`  out  8  LED drive, registered.

## Operation
- Registers:
  - 0 CTRL: [0] HPS_OWN, reset 0.
  - 1 LED_DATA: [7:0], reset 0x00.
  - 2 STEP_DIV: [23:0], reset STEP_DIV_RST.
  - 3 STATUS, read-only: [3:0] debounced switches, [6:4] FSM state, [7] effective owner (1 = HPS).
  - Unused bits read 0; writes to STATUS ignored.
- Switch input: 2-flop synchroniser, then per-bit counter. A bit's debounced value updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Debounced reset value 0.
- Decode: sw[1:0] = mode (00 OFF, 01 COUNT, 10 SHIFT, 11 BOUNCE); sw[2] = pause (steps suppressed, pattern held); sw[3] = local force.
- Arbitration: owner = HPS iff HPS_OWN=1 and sw[3]=0. LED register loads LED_DATA when owner is HPS, else the pattern register. The pattern engine runs regardless of owner.
- Prescaler: counts 0..STEP_DIV-1 and pulses `step` on the terminal count. STEP_DIV=0 is treated as 1, giving a step every cycle. Any STEP_DIV write clears the prescaler.
- FSM states: OFF=0, COUNT=1, SHIFT=2, BNC_L=3, BNC_R=4.
  - Mode change takes effect the cycle after the debounced change. Entry seeds the pattern: OFF→0x00, COUNT→0x00, SHIFT→0x01, BOUNCE→0x01 in BNC_L.
  - COUNT: pattern+1 per step, wraps 0xFF→0x00.
  - SHIFT: rotate left, 0x80→0x01.
  - BNC_L: shift left; on reaching 0x80, next step enters BNC_R.
  - BNC_R: shift right; on reaching 0x01, next step enters BNC_L.
- Simultaneous mode change and step: the mode change wins and the seed is loaded. Pause does not block mode changes.

## Timing
- Reset values: `led_array_io_export`=0x00, `avs_readdata`=0, FSM=OFF, prescaler=0.
- Write: register updates on the cycle `avs_write` is sampled. The LED output reflects a new LED_DATA one cycle later (2 cycles from the strobe edge).
- Read latency is 1 cycle, no wait states. Read and write in the same cycle to the same address returns the old value.
- Pattern step to LED output: 1 cycle. Switch edge to debounced: 2 sync cycles + DEBOUNCE_CYCLES.
- Asynchronous reset mid-step clears all state immediately. First step occurs STEP_DIV_RST cycles after release.

## Configuration
- `LEDSEQ_PWM_EN` defined:
  - STEP_DIV[31:24] = BRIGHT, reset 0xFF.
  - A free-running 8-bit counter c gates the LED output: LEDs are on while c < BRIGHT; BRIGHT=0xFF means always on; BRIGHT=0 means dark.
  - Gating is applied after the LED register (combinational AND with a registered enable).
- Undefined: STEP_DIV[31:24] reads 0 and writes are ignored; no gating.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, STEP_DIV_RST=3.
- Reset, then hold switches 0 → LEDs 0x00; STATUS reads 0x00.
- sw=0001 held for 6+ cycles → COUNT. LEDs step 0x00, 0x01, 0x02 every 3 cycles; after 256 steps the pattern wraps 0xFF→0x00.
- sw=0011 → BOUNCE: 0x01, 0x02 … 0x80, 0x40 … 0x01. STATUS[6:4] reads 3 then 4.
- sw toggled every 2 cycles for 20 cycles → debounced value unchanged, mode unchanged.
- Write CTRL=1 and LED_DATA=0xA5 → LEDs 0xA5. Then set sw[3]=1 and debounce → LEDs return to the pattern; STATUS[7]=0.
- Write STEP_DIV=0 in SHIFT mode → pattern rotates every cycle. With `LEDSEQ_PWM_EN`, BRIGHT=0x40 → LEDs lit 64 of every 256 cycles.

Source files
------------

// File: rtl/led_sequencer.sv
// LED array controller: shares the LEDs between an Avalon-MM register file and a
// switch-selected local pattern engine. Define LEDSEQ_PWM_EN to add brightness gating.
module led_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned STEP_DIV_RST    = 12500000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [3:0]  switch_array_io_export,
    output logic [7:0]  led_array_io_export
);

    localparam int unsigned DbCntW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] StOff   = 3'd0;
    localparam logic [2:0] StCount = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StBncL  = 3'd3;
    localparam logic [2:0] StBncR  = 3'd4;

    logic [3:0]        sw_meta_q, sw_sync_q, sw_db_q;
    logic [DbCntW-1:0] db_cnt_q [4];
    logic              hps_own_q;
    logic [7:0]        led_data_q;
    logic [23:0]       step_div_q;
    logic [23:0]       pre_q, pre_d, div_m1;
    logic [2:0]        state_q, state_d;
    logic [7:0]        pattern_q, pattern_d;
    logic [7:0]        led_q;
    logic [31:0]       readdata_q, rd_mux, step_div_rd;
    logic [1:0]        cur_mode;
    logic              wr_ctrl, wr_led, wr_div;
    logic              step, mode_change, owner_hps;

    assign wr_ctrl   = avs_write && (avs_address == 2'd0);
    assign wr_led    = avs_write && (avs_address == 2'd1);
    assign wr_div    = avs_write && (avs_address == 2'd2);
    assign owner_hps = hps_own_q && !sw_db_q[3];

    // Two-flop synchroniser followed by a per-bit stability counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_db_q   <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sw_meta_q <= switch_array_io_export;
            sw_sync_q <= sw_meta_q;
            for (int i = 0; i < 4; i++) begin
                if (sw_sync_q[i] != sw_db_q[i]) begin
                    if (db_cnt_q[i] == DbCntW'(DEBOUNCE_CYCLES - 1)) begin
                        sw_db_q[i]  <= sw_sync_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // STEP_DIV of zero behaves as one, i.e. a step every cycle.
    assign div_m1 = (step_div_q == 24'd0) ? 24'd0 : step_div_q - 24'd1;
    assign step   = (pre_q == div_m1);

    always_comb begin
        pre_d = pre_q + 24'd1;
        if (wr_div || step) pre_d = '0;
    end

    always_comb begin
        cur_mode = 2'd3;
        case (state_q)
            StOff:   cur_mode = 2'd0;
            StCount: cur_mode = 2'd1;
            StShift: cur_mode = 2'd2;
            default: cur_mode = 2'd3;
        endcase
    end

    assign mode_change = (sw_db_q[1:0] != cur_mode);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        if (mode_change) begin
            unique case (sw_db_q[1:0])
                2'd0: begin state_d = StOff;   pattern_d = 8'h00; end
                2'd1: begin state_d = StCount; pattern_d = 8'h00; end
                2'd2: begin state_d = StShift; pattern_d = 8'h01; end
                2'd3: begin state_d = StBncL;  pattern_d = 8'h01; end
            endcase
        end else if (step && !sw_db_q[2]) begin
            case (state_q)
                StOff:   pattern_d = 8'h00;
                StCount: pattern_d = pattern_q + 8'd1;
                StShift: pattern_d = {pattern_q[6:0], pattern_q[7]};
                StBncL: begin
                    if (pattern_q == 8'h80) begin
                        state_d   = StBncR;
                        pattern_d = 8'h40;
                    end else begin
                        pattern_d = {pattern_q[6:0], 1'b0};
                    end
                end
                StBncR: begin
                    if (pattern_q == 8'h01) begin
                        state_d   = StBncL;
                        pattern_d = 8'h02;
                    end else begin
                        pattern_d = {1'b0, pattern_q[7:1]};
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

`ifdef LEDSEQ_PWM_EN
    logic [7:0] bright_q, pwm_cnt_q;
    logic       pwm_on_q;

    assign step_div_rd = {bright_q, step_div_q};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bright_q  <= 8'hFF;
            pwm_cnt_q <= '0;
            pwm_on_q  <= 1'b1;
        end else begin
            if (wr_div) bright_q <= avs_writedata[31:24];
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            pwm_on_q  <= (bright_q == 8'hFF) || (pwm_cnt_q < bright_q);
        end
    end

    assign led_array_io_export = led_q & {8{pwm_on_q}};
`else
    logic unused_wdata;

    assign unused_wdata        = ^avs_writedata[31:24];
    assign step_div_rd         = {8'h00, step_div_q};
    assign led_array_io_export = led_q;
`endif

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0: rd_mux = {31'd0, hps_own_q};
            2'd1: rd_mux = {24'd0, led_data_q};
            2'd2: rd_mux = step_div_rd;
            2'd3: rd_mux = {24'd0, owner_hps, state_q, sw_db_q};
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hps_own_q  <= 1'b0;
            led_data_q <= 8'h00;
            step_div_q <= 24'(STEP_DIV_RST);
            pre_q      <= '0;
            state_q    <= StOff;
            pattern_q  <= 8'h00;
            led_q      <= 8'h00;
            readdata_q <= '0;
        end else begin
            if (wr_ctrl) hps_own_q  <= avs_writedata[0];
            if (wr_led)  led_data_q <= avs_writedata[7:0];
            if (wr_div)  step_div_q <= avs_writedata[23:0];
            if (avs_read) readdata_q <= rd_mux;
            pre_q     <= pre_d;
            state_q   <= state_d;
            pattern_q <= pattern_d;
            led_q     <= owner_hps ? led_data_q : pattern_q;
        end
    end

    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer (DEBOUNCE_CYCLES=4, STEP_DIV_RST=3).
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [3:0]  sw = '0;
    logic [7:0]  led;

    int errors = 0;
    int checks = 0;

    led_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .STEP_DIV_RST(3)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .switch_array_io_export(sw),
        .led_array_io_export(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        check(tag, avs_readdata, exp);
    endtask

    logic [7:0] bnc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
    logic [7:0] rot;
    logic [31:0] div_fast_rd;
    int lit;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef LEDSEQ_PWM_EN
        div_fast_rd = 32'hFF00_0000;
`else
        div_fast_rd = 32'h0000_0000;
`endif
        #1;
        check("reset_led", {24'd0, led}, 32'h00);
        check("reset_rdata", avs_readdata, 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        rd_check("status_idle", 2'd3, 32'h00);
        rd_check("stepdiv_rst", 2'd2, 32'h3);
        rd_check("ctrl_rst", 2'd0, 32'h0);
        check("led_off", {24'd0, led}, 32'h00);

        // COUNT mode, stepping phase pinned by a STEP_DIV write
        wr(2'd2, 32'hFF00_03E8);
        sw = 4'b0001;
        cycles(10);
        rd_check("status_count", 2'd3, 32'h11);
        check("count_seed", {24'd0, led}, 32'h00);
        wr(2'd2, 32'hFF00_0003);
        for (int k = 1; k <= 9; k++) begin
            cycles(1);
            check($sformatf("count_k%0d", k), {24'd0, led}, 32'((k - 1) / 3));
        end
        wr(2'd2, 32'hFF00_0000);
        for (int k = 1; k <= 255; k++) begin
            cycles(1);
            if (k == 1)   check("count_fast", {24'd0, led}, 32'h03);
            if (k == 253) check("count_ff", {24'd0, led}, 32'hFF);
            if (k == 254) check("count_wrap", {24'd0, led}, 32'h00);
            if (k == 255) check("count_after_wrap", {24'd0, led}, 32'h01);
        end

        // BOUNCE mode
        wr(2'd2, 32'hFF00_03E8);
        sw = 4'b0011;
        cycles(10);
        rd_check("status_bncl", 2'd3, 32'h33);
        check("bnc_seed", {24'd0, led}, 32'h01);
        wr(2'd2, 32'hFF00_0000);
        for (int k = 1; k <= 9; k++) begin
            cycles(1);
            check($sformatf("bnc_k%0d", k), {24'd0, led}, {24'd0, bnc_tab[k - 1]});
        end
        wr(2'd2, 32'hFF00_03E8);
        check("bnc_k10", {24'd0, led}, 32'h20);
        cycles(2);
        check("bnc_frozen", {24'd0, led}, 32'h10);
        rd_check("status_bncr", 2'd3, 32'h43);

        // Switch bounce shorter than the debounce window is rejected
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 4'b0010 : 4'b0011;
            cycles(2);
        end
        sw = 4'b0011;
        cycles(8);
        rd_check("status_bounce_rej", 2'd3, 32'h43);
        check("led_bounce_rej", {24'd0, led}, 32'h10);

        // HPS ownership and local force
        wr(2'd0, 32'h1);
        check("hps_led_lag", {24'd0, led}, 32'h10);
        cycles(1);
        check("hps_led_data0", {24'd0, led}, 32'h00);
        wr(2'd1, 32'hA5);
        check("hps_wr_lag", {24'd0, led}, 32'h00);
        cycles(1);
        check("hps_led_a5", {24'd0, led}, 32'hA5);
        rd_check("status_hps", 2'd3, 32'hC3);
        rd_check("led_data_rd", 2'd1, 32'hA5);
        avs_address   = 2'd1;
        avs_writedata = 32'h5A;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check("rd_wr_same_old", avs_readdata, 32'hA5);
        cycles(1);
        check("hps_led_5a", {24'd0, led}, 32'h5A);
        rd_check("led_data_new", 2'd1, 32'h5A);
        sw = 4'b1011;
        cycles(10);
        check("force_led", {24'd0, led}, 32'h10);
        rd_check("status_force", 2'd3, 32'h4B);

        // SHIFT at one step per cycle, then pause
        sw = 4'b1010;
        cycles(10);
        rd_check("status_shift", 2'd3, 32'h2A);
        check("shift_seed", {24'd0, led}, 32'h01);
        wr(2'd2, 32'hFF00_0000);
        for (int k = 1; k <= 10; k++) begin
            cycles(1);
            rot = 8'h01;
            for (int r = 0; r < (k - 1) % 8; r++) rot = {rot[6:0], rot[7]};
            check($sformatf("shift_k%0d", k), {24'd0, led}, {24'd0, rot});
        end
        sw = 4'b1110;
        for (int j = 1; j <= 16; j++) begin
            cycles(1);
            if (j == 5)  check("pause_pre", {24'd0, led}, 32'h40);
            if (j == 6)  check("pause_last", {24'd0, led}, 32'h80);
            if (j == 7)  check("pause_hold", {24'd0, led}, 32'h01);
            if (j == 16) check("pause_hold_late", {24'd0, led}, 32'h01);
        end
        rd_check("status_pause", 2'd3, 32'h2E);
        rd_check("stepdiv_hi", 2'd2, div_fast_rd);

`ifdef LEDSEQ_PWM_EN
        wr(2'd2, 32'h4000_0000);
        cycles(3);
        lit = 0;
        for (int c = 0; c < 256; c++) begin
            cycles(1);
            if (led != 8'h00) lit++;
        end
        check("pwm_duty", 32'(lit), 32'd64);
        wr(2'd2, 32'hFF00_0000);
`endif

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", {24'd0, led}, 32'h00);
        check("async_rst_rdata", avs_readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_check("rst2_status", 2'd3, 32'h00);
        rd_check("rst2_stepdiv", 2'd2, 32'h3);
        rd_check("rst2_ctrl", 2'd0, 32'h0);
        rd_check("rst2_led_data", 2'd1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
